fifo_rr_drain: RTL and testbench
================================

# fifo_rr_drain

Round-robin drain stage sitting directly downstream of a bank of `fifo` instances in the arbitrated-FIFO subsystem. It watches every FIFO's `empty`/`data_out`, issues at most one `pop` per cycle to the granted FIFO, and captures the popped word into a single output register with a valid/ready handshake. Grants rotate fairly so no non-empty FIFO waits more than NUM_FIFOS-1 grants.

## Interface
- `NUM_FIFOS`, default 4: number of upstream FIFOs, at least 2, need not be a power of two.
- `WIDTH`, default 8: data width, matching the upstream `fifo` WIDTH.
- `IDW`, default `$clog2(NUM_FIFOS)`: width of the source-index field.

- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-low reset. Asserting it (0) clears state immediately; deassertion is taken synchronously to `clk`.
- `empty`  in  NUM_FIFOS: per-FIFO empty flags; bit i belongs to FIFO i.
- `fifo_data`  in  NUM_FIFOS*WIDTH: concatenated FIFO `data_out`; FIFO i occupies bits [i*WIDTH +: WIDTH].
- `pop`  out  NUM_FIFOS: one-hot-or-zero pop strobes to the FIFOs.
- `out_valid`  out  1: output register holds a word.
- `out_ready`  in  1: consumer accepts the word this cycle.
- `out_data`  out  WIDTH: registered word.
- `out_id`  out  IDW: index of the FIFO `out_data` came from.

## Operation
- Request vector: `req = ~empty`.
- Priority pointer `ptr` (IDW bits, range 0..NUM_FIFOS-1).
  - Grant `g` is the first i with `req[i]`, scanning `ptr, ptr+1, ..., NUM_FIFOS-1, 0, ...`.
  - Wrap-around is modulo NUM_FIFOS, not 2^IDW.
- Load condition: `load = |req & (~out_valid | out_ready) & rst`.
- `pop` is combinational:
  - `pop[g] = load`; all other bits 0.
  - `pop` is never asserted to an empty FIFO and is never multi-hot.
- On a load edge:
  - `out_data <= fifo_data[g]`, sampled in the same cycle as `pop`, because FIFO `data_out` is combinational from its read pointer.
  - `out_id <= g`.
  - `out_valid <= 1`.
  - `ptr <= (g == NUM_FIFOS-1) ? 0 : g+1`.
- Output register has two states:
  - EMPTY (`out_valid = 0`): loads whenever any request is present.
  - FULL (`out_valid = 1`): on `out_ready & load`, the register is replaced, giving back-to-back transfer. On `out_ready & ~load` it returns to EMPTY. With `~out_ready` it holds `out_data`/`out_id` stable and `pop` stays 0.
- `ptr` changes only on load.

## Timing
- Reset values: `out_valid = 0`, `out_data = 0`, `out_id = 0`, `ptr = 0`, `pop = 0`. `pop` is forced to 0 combinationally while `rst` = 0.
- Latency: a FIFO going non-empty in cycle N produces `pop` in cycle N, given the register is EMPTY or draining. `out_valid` is high in cycle N+1.
- Throughput: one word per cycle while `out_ready` stays high and any FIFO is non-empty.
- Fairness bound: a continuously non-empty FIFO is granted within NUM_FIFOS loads.
- Reset mid-operation: a held word is discarded and `out_valid` drops asynchronously. The FIFOs are not popped for the discarded word, because the pop already occurred at load.

## Structure
- Package `arb_pkg` holds the index-width helper and the `NUM_FIFOS`/`WIDTH` defaults shared with the FIFO bank wrapper.
- Sub-module `rr_pick`: combinational; inputs `req` and `ptr`, outputs `gnt_idx` and `gnt_any`. It is instantiated once. It implements the rotate, priority-encode and unrotate steps, with modulo-NUM_FIFOS handling.
- Output register and pointer live in `fifo_rr_drain`.
- Under `FORMAL`, the block carries assertions for:
  - `$onehot0(pop)`;
  - `pop & empty == 0`;
  - `out_data`/`out_id` stable while `out_valid & ~out_ready`.

## Test plan
- Reset then idle: `rst` = 0 for 2 cycles, all `empty` = 1 → all outputs 0, `pop` = 0. After release, `pop` stays 0.
- Single source, NUM_FIFOS = 4: FIFO 2 holds 0x11, 0x22; `out_ready` = 1 → `pop[2]` in cycles 0 and 1; `out_data` 0x11 then 0x22, `out_id` = 2; `ptr` ends at 3.
- All-full round-robin: four FIFOs each holding 3 words, `out_ready` = 1 → `out_id` sequence 0,1,2,3,0,1,2,3,… for 12 cycles with no bubbles.
- Backpressure: `out_ready` = 0 for 5 cycles with a word held → `pop` = 0 throughout and `out_data`/`out_id` unchanged. First `out_ready` = 1 cycle pops the next grant.
- Non-power-of-two wrap: NUM_FIFOS = 3, only FIFO 2 and FIFO 0 non-empty, `ptr` = 2 → grants 2 then 0, never index 3.
- Reset mid-stream: deassert `out_ready`, assert `rst` for 1 cycle → `out_valid` drops immediately and `ptr` = 0. After release, FIFO 0 is granted first when non-empty.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared defaults and helpers for the arbitrated-FIFO subsystem: the FIFO bank
// wrapper and the round-robin drain stage both size themselves from here.
package arb_pkg;

  localparam int DEF_NUM_FIFOS = 4;
  localparam int DEF_WIDTH     = 8;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Width of a source index; a single source still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate requests so ptr sits at position 0,
// take the lowest set bit, then map that offset back to a FIFO index.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_FIFOS = DEF_NUM_FIFOS,
  parameter int IDW       = idx_width(NUM_FIFOS)
) (
  input  logic [NUM_FIFOS-1:0] req,
  input  logic [IDW-1:0]       ptr,
  output logic [IDW-1:0]       gnt_idx,
  output logic                 gnt_any
);

  logic [NUM_FIFOS-1:0] rot;
  logic [IDW-1:0]       off;

  // Both operands are below NUM_FIFOS, so one conditional subtract gives the
  // modulo-NUM_FIFOS sum even when NUM_FIFOS is not a power of two.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a,
                                              input logic [IDW-1:0] b);
    logic [IDW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (IDW+1)'(NUM_FIFOS)) sum = sum - (IDW+1)'(NUM_FIFOS);
    return sum[IDW-1:0];
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves a value held and no latch is inferred.
    rot = '0;
    for (int k = 0; k < NUM_FIFOS; k++) rot[k] = req[wrap_add(ptr, IDW'(k))];
  end

  always_comb begin
    gnt_any = |rot;
    off     = '0;
    for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
      if (rot[k]) off = IDW'(k);
    end
  end

  assign gnt_idx = wrap_add(ptr, off);

endmodule

// File: rtl/fifo_rr_drain.sv
// Round-robin drain stage: pops at most one non-empty upstream FIFO per cycle
// into a single valid/ready output register tagged with its source index.
module fifo_rr_drain
  import arb_pkg::*;
#(
  parameter int NUM_FIFOS = DEF_NUM_FIFOS,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int IDW       = idx_width(NUM_FIFOS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_FIFOS-1:0]       empty,
  input  logic [NUM_FIFOS*WIDTH-1:0] fifo_data,
  output logic [NUM_FIFOS-1:0]       pop,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [IDW-1:0]             out_id
);

  logic [NUM_FIFOS-1:0] req;
  logic [IDW-1:0]       ptr;
  logic [IDW-1:0]       gnt_idx;
  logic                 gnt_any;
  logic                 load;
  logic [WIDTH-1:0]     fifo_word [NUM_FIFOS];
  out_state_e           state;

  assign req = ~empty;

  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_unpack
    assign fifo_word[i] = fifo_data[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NUM_FIFOS (NUM_FIFOS),
    .IDW       (IDW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // rst gates load so no FIFO is popped while the register is held in reset.
  assign load      = gnt_any & (~out_valid | out_ready) & rst;
  assign out_valid = (state == OUT_FULL);

  always_comb begin
    pop = '0;
    if (load) pop[gnt_idx] = 1'b1;
  end

  // FIFO data_out is combinational from its read pointer, so the word is
  // captured on the same edge that retires it upstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: out_data is reset too; consumers may look at it before the first
      // load, and a known zero keeps the bus quiet after a mid-stream reset.
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state    <= OUT_EMPTY;
      out_data <= '0;
      out_id   <= '0;
      ptr      <= '0;
    end else if (load) begin
      state    <= OUT_FULL;
      out_data <= fifo_word[gnt_idx];
      out_id   <= gnt_idx;
      ptr      <= (gnt_idx == IDW'(NUM_FIFOS - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_ready) begin
      state <= OUT_EMPTY;
    end
  end

`ifdef FORMAL
  a_pop_onehot0 : assert property (@(posedge clk) disable iff (!rst)
    $onehot0(pop));
  a_pop_nonempty : assert property (@(posedge clk) disable iff (!rst)
    (pop & empty) == '0);
  a_hold_stable : assert property (@(posedge clk) disable iff (!rst)
    (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_id)));
`endif

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Bench for fifo_rr_drain: queue-modelled FIFOs, a round-robin reference model
// and a decoupled output monitor, plus a NUM_FIFOS=3 wrap-around instance.
module tb_fifo_rr_drain;
  import arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   empty;
  logic [N*W-1:0] fifo_data;
  logic [N-1:0]   pop;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_id;

  logic [2:0]     empty3;
  logic [3*W-1:0] data3;
  logic [2:0]     pop3;
  logic           valid3;
  logic           ready3;
  logic [W-1:0]   odata3;
  logic [1:0]     oid3;

  always #5 clk = ~clk;

  fifo_rr_drain #(.NUM_FIFOS(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .empty     (empty),
    .fifo_data (fifo_data),
    .pop       (pop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  fifo_rr_drain #(.NUM_FIFOS(3), .WIDTH(W)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .empty     (empty3),
    .fifo_data (data3),
    .pop       (pop3),
    .out_valid (valid3),
    .out_ready (ready3),
    .out_data  (odata3),
    .out_id    (oid3)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  data;
  } exp_t;

  exp_t         exp_q [$];
  logic [W-1:0] src_q [N][$];
  int           checks = 0;
  int           errors = 0;
  int           transfers = 0;
  int           model_ptr = 0;
  bit           model_valid = 1'b0;
  int unsigned  fill_pct = 0;
  int unsigned  ready_pct = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present the modelled FIFO heads to the DUT, optionally refilling at random.
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(99) < fill_pct && src_q[i].size() < 4)
        src_q[i].push_back(W'($urandom));
      empty[i]            = (src_q[i].size() == 0);
      fifo_data[i*W +: W] = (src_q[i].size() != 0) ? src_q[i][0] : W'(0);
    end
    out_ready = ($urandom_range(99) < ready_pct);
  endtask

  // Reference model: grant the first non-empty FIFO at or after the pointer.
  task automatic step();
    int  g;
    bit  any;
    bit  load;
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(model_valid));
    any = 1'b0;
    g   = 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (model_ptr + k) % N;
      if (!any && src_q[i].size() > 0) begin
        any = 1'b1;
        g   = i;
      end
    end
    load = any && (!model_valid || out_ready);
    check("pop", 64'(pop), load ? (64'd1 << g) : 64'd0);
    if (load) begin
      exp_q.push_back(exp_t'{id: IW'(g), data: src_q[g][0]});
      void'(src_q[g].pop_front());
      model_ptr   = (g + 1) % N;
      model_valid = 1'b1;
    end else if (out_ready) begin
      model_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  // Called at posedge+1; pulses rst for one cycle and restarts the model.
  task automatic reset_pulse(input bit do_checks);
    #2 rst = 1'b0;
    #1;
    if (do_checks) begin
      check("rst_valid_drop", 64'(out_valid), 64'd0);
      check("rst_pop_gated", 64'(pop), 64'd0);
      check("rst_ptr", 64'(dut.ptr), 64'd0);
      check("rst_out_id", 64'(out_id), 64'd0);
    end
    exp_q.delete();
    model_valid = 1'b0;
    model_ptr   = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    drive();
  endtask

  // Monitor: whenever a word is presented it must match the oldest expected one.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got id %0d data %0h expected no word", out_id, out_data);
      end else begin
        check("out_id", 64'(out_id), 64'(exp_q[0].id));
        check("out_data", 64'(out_data), 64'(exp_q[0].data));
        if (out_ready) begin
          void'(exp_q.pop_front());
          transfers++;
        end
      end
    end
  end

  initial begin
    int base;
    int prev;
    int exp_g;
    rst       = 1'b1;
    empty     = '1;
    fifo_data = '0;
    out_ready = 1'b0;
    empty3    = '1;
    data3     = '0;
    ready3    = 1'b0;

    // Reset then idle.
    #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("reset_valid", 64'(out_valid), 64'd0);
      check("reset_data", 64'(out_data), 64'd0);
      check("reset_id", 64'(out_id), 64'd0);
      check("reset_pop", 64'(pop), 64'd0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    drive();
    run(3);

    // Single source: FIFO 2 holds 0x11, 0x22.
    src_q[2].push_back(8'h11);
    src_q[2].push_back(8'h22);
    drive();
    base = transfers;
    run(4);
    check("single_transfers", 64'(transfers - base), 64'd2);
    check("single_ptr", 64'(dut.ptr), 64'd3);

    // All FIFOs hold three words: strict 0,1,2,3 rotation, no bubbles.
    reset_pulse(1'b0);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      for (int j = 0; j < 3; j++) src_q[i].push_back(W'($urandom));
    end
    drive();
    base = transfers;
    run(13);
    check("allfull_transfers", 64'(transfers - base), 64'd12);

    // Backpressure: one word held for five cycles, then released.
    for (int i = 0; i < N; i++) begin
      src_q[i].push_back(W'($urandom));
      src_q[i].push_back(W'($urandom));
    end
    ready_pct = 0;
    drive();
    run(6);
    ready_pct = 100;
    drive();
    run(12);

    // Randomised traffic with random backpressure, then drain.
    fill_pct  = 40;
    ready_pct = 60;
    drive();
    run(300);
    fill_pct  = 0;
    ready_pct = 100;
    drive();
    run(25);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-stream with a held word; FIFO 0 must be granted first after.
    for (int i = 0; i < N; i++) begin
      src_q[i].push_back(W'($urandom));
      src_q[i].push_back(W'($urandom));
    end
    ready_pct = 0;
    drive();
    run(2);
    reset_pulse(1'b1);
    ready_pct = 100;
    drive();
    run(12);
    check("midrst_drain", 64'(exp_q.size()), 64'd0);

    // NUM_FIFOS = 3: FIFO 1 alone moves ptr to 2, then FIFOs 2 and 0 alternate.
    data3  = {8'hC2, 8'hB1, 8'hA0};
    empty3 = 3'b101;
    ready3 = 1'b1;
    @(negedge clk);
    check("n3_pop_first", 64'(pop3), 64'b010);
    @(posedge clk);
    #1 empty3 = 3'b010;
    prev = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp_g = (c % 2 == 0) ? 2 : 0;
      check("n3_valid", 64'(valid3), 64'd1);
      check("n3_id", 64'(oid3), 64'(prev));
      check("n3_data", 64'(odata3), 64'(8'hA0 + prev * 8'h11));
      check("n3_pop", 64'(pop3), 64'd1 << exp_g);
      prev = exp_g;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
